// File: rtl/rv_mc_exec_unit.sv
// Execution/control cluster of the RV32I multicycle core: Moore control FSM,
// combinational ALU and the 32-entry register file with x0 tied to zero.
//
// state  | meaning
// IF     | fetch: IR <= mem, PC <= PC + 4
// ID     | decode opcode, choose execute flavour
// EX_R   | ALU on A, B with R-type operation
// EX_I   | ALU on A, I-immediate (load address or I-type op)
// EX_S   | store address A + S-immediate
// EX_J   | link value PC + 0 (PC already holds jal_pc + 4)
// MEM_RD | load read
// MEM_WR | store write
// WB_ALU | write ALUOut to rd; for JAL also redirect PC
// WB_MEM | write MDR to rd
// HALT   | stopped until reset
module rv_mc_exec_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic [3:0]      state,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            ir_write,
  output logic            pc_write,
  output logic            mem_to_reg,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      imm_src,
  output logic [3:0]      alu_control
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX_R = 4'd2, S_EX_I = 4'd3, S_EX_S = 4'd4,
    S_EX_J = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7, S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9, S_HALT = 4'd10
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLL = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8,
                         ALU_SLTU = 4'd9;

  state_t cur_state, next_state;
  logic   unused_funct7;

  assign state         = cur_state;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // funct7[5] picks SUB only for register-register ops; SRA/SRL for both.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic is_r);
    case (f3)
      3'b000:  alu_decode = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IF;
    else       cur_state <= next_state;
  end

  always_comb begin
    next_state = S_IF;
    case (cur_state)
      S_IF: next_state = S_ID;
      S_ID: begin
        case (opcode)
          OP_R:        next_state = S_EX_R;
          OP_I, OP_LD: next_state = S_EX_I;
          OP_S:        next_state = S_EX_S;
          OP_JAL:      next_state = S_EX_J;
          default:     next_state = S_HALT;
        endcase
      end
      S_EX_R:   next_state = S_WB_ALU;
      S_EX_I:   next_state = (opcode == OP_LD) ? S_MEM_RD : S_WB_ALU;
      S_EX_S:   next_state = S_MEM_WR;
      S_EX_J:   next_state = S_WB_ALU;
      S_MEM_RD: next_state = S_WB_MEM;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IF;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = ALU_ADD;
    case (cur_state)
      S_IF: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b10;
      end
      S_EX_R: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decode(funct3, funct7[5], 1'b1);
      end
      S_EX_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = (opcode == OP_LD) ? ALU_ADD : alu_decode(funct3, funct7[5], 1'b0);
      end
      S_EX_S: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = 2'b01;
      end
      S_EX_J:   alu_src_b = 2'b11;
      S_MEM_RD: mem_read  = 1'b1;
      S_MEM_WR: mem_write = 1'b1;
      S_WB_ALU: begin
        reg_write = 1'b1;
        if (opcode == OP_JAL) begin
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          imm_src   = 2'b11;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_control)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLL:  alu_result = alu_a << alu_b[4:0];
      ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_write && rd != 5'd0) begin
      regs[rd] <= write_data;
    end
  end

  assign read_data1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign read_data2 = (rs2 == 5'd0) ? '0 : regs[rs2];

endmodule

// File: tb/tb_rv_mc_exec_unit.sv
// Bench for rv_mc_exec_unit: per-instruction state sequences, control table,
// ALU arithmetic and a register array model, checked every falling edge.
module tb_rv_mc_exec_unit;

  localparam int IF = 0, ID = 1, EX_R = 2, EX_I = 3, EX_S = 4, EX_J = 5,
                 MEM_RD = 6, MEM_WR = 7, WB_ALU = 8, WB_MEM = 9, HALT = 10;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_S = 7'b0100011, OP_JAL = 7'b1101111;

  logic        clk, reset;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] alu_a, alu_b, alu_result, write_data, read_data1, read_data2;
  logic        zero;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  state, alu_control;
  logic        mem_read, mem_write, reg_write, ir_write, pc_write, mem_to_reg;
  logic [1:0]  alu_src_a, alu_src_b, imm_src;

  rv_mc_exec_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .zero(zero),
    .rs1(rs1), .rs2(rs2), .rd(rd), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2), .state(state),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .ir_write(ir_write), .pc_write(pc_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int exp_state = IF;
  bit chk_en = 0, rnd = 0;
  logic [31:0] mdl [32];

  bit lit_en = 0, lit_rd_en = 0;
  int lit_state;
  logic [31:0] lit_res, lit_rd1;
  logic        lit_zero;
  logic [2:0]  d_f3;
  logic [6:0]  d_f7;
  logic [31:0] d_a, d_b, d_wd;
  logic [4:0]  d_rs1, d_rs2, d_rd;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t (state %0d): got %h expected %h", nm, $time, exp_state, got, exp);
    end
  endtask

  // {mem_read, mem_write, reg_write, ir_write, pc_write, mem_to_reg, src_a, src_b, imm_src}
  function automatic logic [11:0] exp_ctl(input int s, input logic [6:0] op);
    logic mr = 0, mw = 0, rw = 0, irw = 0, pcw = 0, m2r = 0;
    logic [1:0] sa = 0, sb = 0, im = 0;
    if (s == IF)     begin irw = 1; pcw = 1; sb = 2'b10; end
    if (s == EX_R)   sa = 2'b10;
    if (s == EX_I)   begin sa = 2'b10; sb = 2'b01; end
    if (s == EX_S)   begin sa = 2'b10; sb = 2'b01; im = 2'b01; end
    if (s == EX_J)   sb = 2'b11;
    if (s == MEM_RD) mr = 1;
    if (s == MEM_WR) mw = 1;
    if (s == WB_ALU) begin
      rw = 1;
      if (op == OP_JAL) begin pcw = 1; sb = 2'b01; im = 2'b11; end
    end
    if (s == WB_MEM) begin rw = 1; m2r = 1; end
    return {mr, mw, rw, irw, pcw, m2r, sa, sb, im};
  endfunction

  function automatic logic [3:0] exp_alu_ctl(input int s, input logic [6:0] op,
                                             input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] tbl [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    logic [3:0] c;
    if (s != EX_R && s != EX_I) return 4'd0;
    if (s == EX_I && op == OP_LD) return 4'd0;
    c = tbl[f3];
    if (f7[5] && f3 == 3'd5) c = 4'd7;
    if (f7[5] && f3 == 3'd0 && s == EX_R) c = 4'd1;
    return c;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa = a, sb = b;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return sa >>> b[4:0];
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0]  ec;
      logic [31:0] er;
      ec = exp_alu_ctl(exp_state, opcode, funct3, funct7);
      er = alu_ref(ec, alu_a, alu_b);
      check("state", {28'd0, state}, exp_state);
      check("ctrl", {20'd0, mem_read, mem_write, reg_write, ir_write, pc_write, mem_to_reg,
                     alu_src_a, alu_src_b, imm_src}, {20'd0, exp_ctl(exp_state, opcode)});
      check("alu_control", {28'd0, alu_control}, {28'd0, ec});
      check("alu_result", alu_result, er);
      check("zero", {31'd0, zero}, {31'd0, er == 32'd0});
      check("read_data1", read_data1, (rs1 == 0) ? 32'd0 : mdl[rs1]);
      check("read_data2", read_data2, (rs2 == 0) ? 32'd0 : mdl[rs2]);
    end
  end

  task automatic do_cycle(input int s, input bit rst);
    exp_state = s;
    reset = rst;
    if (rnd) begin
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      alu_b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      alu_a = ($urandom_range(0, 3) == 0) ? alu_b : $urandom;
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 3) == 0) rs1 = rd;
      write_data = $urandom;
    end else begin
      funct3 = d_f3; funct7 = d_f7; alu_a = d_a; alu_b = d_b;
      rs1 = d_rs1; rs2 = d_rs2; rd = d_rd; write_data = d_wd;
    end
    #4;
    if (lit_en && s == lit_state) begin
      check("lit_alu_result", alu_result, lit_res);
      check("lit_zero", {31'd0, zero}, {31'd0, lit_zero});
    end
    if (lit_rd_en && s == IF) check("lit_read_data1", read_data1, lit_rd1);
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    else if ((s == WB_ALU || s == WB_MEM) && rd != 5'd0) mdl[rd] = write_data;
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int hold);
    int q[$];
    bit halted = 0;
    opcode = op;
    q = '{IF, ID};
    case (op)
      OP_R:        q = '{IF, ID, EX_R, WB_ALU};
      OP_I:        q = '{IF, ID, EX_I, WB_ALU};
      OP_LD:       q = '{IF, ID, EX_I, MEM_RD, WB_MEM};
      OP_S:        q = '{IF, ID, EX_S, MEM_WR};
      OP_JAL:      q = '{IF, ID, EX_J, WB_ALU};
      default:     begin q.push_back(HALT); halted = 1; end
    endcase
    foreach (q[i]) begin
      bit rst = rnd && ($urandom_range(0, 59) == 0);
      do_cycle(q[i], rst);
      if (rst) return;
    end
    if (halted) begin
      repeat (hold) do_cycle(HALT, 1'b0);
      do_cycle(HALT, 1'b1);
    end
  endtask

  task automatic set_lit(input int s, input logic [31:0] r, input logic z);
    lit_en = 1; lit_state = s; lit_res = r; lit_zero = z;
  endtask

  initial begin
    reset = 1; opcode = 0; funct3 = 0; funct7 = 0; alu_a = 0; alu_b = 0;
    rs1 = 0; rs2 = 0; rd = 0; write_data = 0;
    d_f3 = 0; d_f7 = 0; d_a = 0; d_b = 0; d_wd = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    chk_en = 1;
    d_rs1 = 5; d_rs2 = 31;
    do_cycle(IF, 1'b1);

    d_f3 = 3'b010; d_a = 32'd100; d_b = 32'd24; d_rd = 3; d_wd = 32'h1234_5678;
    set_lit(EX_I, 32'd124, 1'b0);
    run_instr(OP_LD, 0);

    d_f3 = 3'b000; d_f7 = 7'b0100000; d_a = 5; d_b = 7; d_rd = 5; d_wd = 32'hDEADBEEF;
    set_lit(EX_R, 32'hFFFF_FFFE, 1'b0);
    run_instr(OP_R, 0);
    d_a = 7; d_b = 7;
    lit_rd_en = 1; lit_rd1 = 32'hDEADBEEF;
    set_lit(EX_R, 32'd0, 1'b1);
    run_instr(OP_R, 0);

    d_f3 = 3'b101; d_a = 32'h8000_0000; d_b = 1; d_rd = 0; d_wd = 32'hFFFF_FFFF;
    set_lit(EX_R, 32'hC000_0000, 1'b0);
    run_instr(OP_R, 0);
    d_f7 = 7'b0000000; d_rs1 = 0; lit_rd1 = 32'd0;
    set_lit(EX_R, 32'h4000_0000, 1'b0);
    run_instr(OP_R, 0);
    d_f3 = 3'b010; set_lit(EX_R, 32'd1, 1'b0);
    run_instr(OP_R, 0);
    d_f3 = 3'b011; set_lit(EX_R, 32'd0, 1'b1);
    run_instr(OP_R, 0);
    lit_en = 0; lit_rd_en = 0;

    d_rd = 7; d_wd = 32'hCAFE_0001;
    run_instr(OP_S, 0);
    run_instr(OP_JAL, 0);
    run_instr(7'b0000000, 6);
    run_instr(7'b1110011, 5);

    rnd = 1;
    for (int n = 0; n < 400; n++) begin
      int k = $urandom_range(0, 19);
      logic [6:0] op;
      if (k < 5)       op = OP_R;
      else if (k < 9)  op = OP_I;
      else if (k < 12) op = OP_LD;
      else if (k < 15) op = OP_S;
      else if (k < 18) op = OP_JAL;
      else if (k == 18) op = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b1110011;
      else             op = 7'($urandom);
      run_instr(op, $urandom_range(5, 8));
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_mc_exec_unit.md
Name: rv_mc_exec_unit

Overview:
Execution/control cluster of the RV32I multicycle core. It contains three parts:
- the multicycle control FSM;
- a 32-bit combinational ALU;
- the 32x32 register file.

The surrounding datapath owns PC, IR, A, B, ALUOut, MDR, the operand muxes and the memory interface. It feeds instruction fields and ALU operands in, and consumes the control strobes, ALU result and register read data.

Parameters:
XLEN, 32, datapath width (ALU, register file).
NREGS, 32, number of architectural registers (x0 hard-wired to zero).

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
opcode/funct3/funct7  in  7/3/7  fields of the latched IR
alu_a, alu_b  in  32 each  ALU operands selected by datapath
alu_result  out  32  combinational ALU output
zero  out  1  alu_result == 0
rs1, rs2, rd  in  5 each  register addresses
write_data  in  32  register write value (ALUOut or MDR, chosen by datapath)
read_data1, read_data2  out  32 each  asynchronous register reads
state  out  4  FSM state code
mem_read, mem_write, reg_write, ir_write, pc_write, mem_to_reg  out  1 each  control strobes
alu_src_a  out  2  operand A select: 00 = PC, 10 = A, 01/11 = zero
alu_src_b  out  2  operand B select: 00 = B, 01 = imm, 10 = constant 4, 11 = zero
imm_src  out  2  immediate select: 00 = I, 01 = S, 10 = J, 11 = J-immediate minus 4
alu_control  out  4  ALU operation code

Behaviour:
- Reset (synchronous): state = IF; all 32 registers cleared to 0.
- All control outputs are Moore (decoded from state plus IR fields). Every strobe not listed for a state is 0; alu_src/imm_src default to 00.
- State codes: IF=0, ID=1, EX_R=2, EX_I=3, EX_S=4, EX_J=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, HALT=10.
- IF: ir_write=1, pc_write=1, src_a=00, src_b=10, ADD (PC+4). Next: ID.
- ID: no strobes. Next state by opcode:
  - 0110011 -> EX_R
  - 0010011 or 0000011 -> EX_I
  - 0100011 -> EX_S
  - 1101111 -> EX_J
  - anything else (incl. 1110011) -> HALT
- EX_R: src_a=10, src_b=00, alu_control = R-decode. Next: WB_ALU.
- EX_I: src_a=10, src_b=01, imm_src=00. alu_control is ADD for loads, otherwise I-decode. Next: MEM_RD for loads, else WB_ALU.
- EX_S: src_a=10, src_b=01, imm_src=01, ADD. Next: MEM_WR.
- EX_J: src_a=00, src_b=11, ADD. This yields the link value (PC already holds jal_pc+4). Next: WB_ALU.
- MEM_RD: mem_read=1. Next: WB_MEM.
- MEM_WR: mem_write=1. Next: IF.
- WB_ALU: reg_write=1, mem_to_reg=0. If opcode is JAL, also pc_write=1, src_a=00, src_b=01, imm_src=11 (target = jal_pc + imm_j). Next: IF.
- WB_MEM: reg_write=1, mem_to_reg=1. Next: IF.
- HALT: no strobes; remains until reset.
- Unused state codes go to IF.
- R-decode by funct3:
  - 000: SUB if funct7[5], else ADD
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101: SRA if funct7[5], else SRL
  - 110 OR, 111 AND
- I-decode: same table, except 000 is always ADD.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA (shift amount = alu_b[4:0])
  - 1000 SLT (signed), 1001 SLTU (result 0 or 1)
  - other codes -> 0
  - Wrap-around modulo 2^32; zero tracks alu_result.
- Register file:
  - Write on rising edge when reg_write=1 and rd!=0; writes to x0 are ignored.
  - Reads are combinational; x0 always reads 0.
  - Same-cycle read of the register being written returns the old value.
- Reset during any state forces IF on the next edge, even from HALT.
- A cycle with reset=1 performs no register write.

Test Plan:
- Reset, then lw opcode 0000011: state sequence IF,ID,EX_I,MEM_RD,WB_MEM,IF. mem_read=1 only in MEM_RD; mem_to_reg=1 and reg_write=1 in WB_MEM.
- add then sub, funct7=0100000, alu_a=5, alu_b=7: sub gives alu_result=0xFFFFFFFE, zero=0. With alu_a=alu_b=7: result=0, zero=1.
- Shifts/compares on alu_a=0x80000000, alu_b=1:
  - SRA = 0xC0000000, SRL = 0x40000000
  - SLT(0x80000000,1) = 1, SLTU = 0
- Register file: write 0xDEADBEEF to x5 -> read_data1 at rs1=5 next cycle = 0xDEADBEEF. Write to x0 -> x0 still reads 0.
- sw opcode 0100011: IF,ID,EX_S (imm_src=01),MEM_WR (mem_write=1),IF; reg_write never asserted.
- jal: WB_ALU asserts reg_write, pc_write, imm_src=11. Opcode 0000000: ID -> HALT, held 5+ cycles, then reset returns to IF.
